// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency instruction
// memory and registers each returned word with its PC into the IF/ID register.
//
// state | meaning
// RUN   | issuing addresses and delivering words to IF/ID
// HALT  | a zero word was fetched; fetch is parked until a redirect
module fetch_unit #(
    parameter int unsigned RESET_PC     = 0,
    parameter int unsigned MEM_DEPTH    = 256,
    parameter bit          HALT_ON_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic        ifid_valid,
    output logic        halted,
    output logic [31:0] instr_count
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [AW-1:0] RESET_PC_W = RESET_PC[AW-1:0];

    typedef enum logic {RUN, HALT} state_t;

    state_t        state;
    logic [AW-1:0] pc;
    logic [AW-1:0] fetch_pc_q;
    logic          fetch_vld_q;
    logic [AW-1:0] ifid_pc_q;
    logic [AW-1:0] addr_sel;
    logic          halt_hit;
    logic          unused_redirect_hi;

    assign unused_redirect_hi = ^redirect_pc[31:AW];

    // While stalled or halted, re-read the in-flight word so mem_data stays stable.
    assign addr_sel = (state == RUN && !stall) ? pc : fetch_pc_q;
    assign mem_addr = {{(32-AW){1'b0}}, addr_sel};
    assign ifid_pc  = {{(32-AW){1'b0}}, ifid_pc_q};
    assign halted   = (state == HALT);
    assign halt_hit = fetch_vld_q && HALT_ON_ZERO && (mem_data == 32'h0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= RUN;
            pc          <= RESET_PC_W;
            fetch_pc_q  <= '0;
            fetch_vld_q <= 1'b0;
            ifid_instr  <= '0;
            ifid_pc_q   <= '0;
            ifid_valid  <= 1'b0;
            instr_count <= '0;
        end else if (state == HALT) begin
            ifid_valid <= 1'b0;
            if (redirect) begin
                pc          <= redirect_pc[AW-1:0];
                fetch_vld_q <= 1'b0;
                state       <= RUN;
            end
        end else begin
            if (redirect) begin
                pc          <= redirect_pc[AW-1:0];
                fetch_vld_q <= 1'b0;
                ifid_valid  <= 1'b0;
            end else if (stall) begin
                state <= RUN;
            end else if (halt_hit) begin
                state       <= HALT;
                ifid_valid  <= 1'b0;
                fetch_vld_q <= 1'b0;
            end else begin
                ifid_instr  <= mem_data;
                ifid_pc_q   <= fetch_pc_q;
                ifid_valid  <= fetch_vld_q;
                fetch_pc_q  <= pc;
                fetch_vld_q <= 1'b1;
                pc          <= pc + AW'(1);
                if (fetch_vld_q) begin
                    instr_count <= instr_count + 32'd1;
                end
            end
        end
    end

endmodule
